// File: rtl/memory_sequencer_if.sv
// Bundle of every signal between the memory sequencer and its neighbours:
// fetch stage 0 (fetch_*/instr_data/block_fetch/pc_advance/halting), the
// memory stage (data_*) and the external 32-bit memory bus (mem_*).
// master = the sequencer itself, slave = everything around it.
interface memory_sequencer_if #(
    parameter int ADDR_WIDTH = 30
);
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic                  fetch_restart;
    logic                  halting;
    logic                  data_req;
    logic                  data_write;
    logic [ADDR_WIDTH-1:0] data_address;
    logic [31:0]           data_wdata;
    logic [31:0]           data_rdata;
    logic                  data_ack;
    logic [31:0]           instr_data;
    logic                  block_fetch;
    logic                  pc_advance;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        input  fetch_address, fetch_restart, halting,
        input  data_req, data_write, data_address, data_wdata,
        input  mem_rdata,
        output data_rdata, data_ack, instr_data, block_fetch, pc_advance,
        output mem_address, mem_read, mem_write, mem_wdata
    );

    modport slave (
        output fetch_address, fetch_restart, halting,
        output data_req, data_write, data_address, data_wdata,
        output mem_rdata,
        input  data_rdata, data_ack, instr_data, block_fetch, pc_advance,
        input  mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/memory_sequencer.sv
// Purpose: owns the external memory bus; arbitrates instruction fetch vs load/store.
// Latency: every bus access takes WAIT_STATES+1 cycles; fetch word appears on its final cycle.
// Backpressure: data_req waits for the current fetch; block_fetch=1 stalls stage 0 with a NOP.
//
// Ports: clock / reset (async, active-low) plus bus (memory_sequencer_if.master):
//   fetch_address/fetch_restart/halting in, instr_data/block_fetch/pc_advance out;
//   data_req/data_write/data_address/data_wdata in, data_rdata/data_ack out;
//   mem_address/mem_read/mem_write/mem_wdata out, mem_rdata in.
module memory_sequencer #(
    parameter int ADDR_WIDTH  = 30,
    parameter int WAIT_STATES = 0
) (
    input  logic                clock,
    input  logic                reset,
    memory_sequencer_if.master  bus
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] WAIT_RELOAD = 4'(WAIT_STATES);

    logic [1:0] state;
    logic [3:0] wait_count;
    logic       last_cycle;

    assign last_cycle = (wait_count == 4'd0);

    // Read data is routed straight through; block_fetch / data_ack qualify it.
    assign bus.instr_data = bus.mem_rdata;
    assign bus.data_rdata = bus.mem_rdata;

    // Outputs decode from state. They are also gated by reset so the bus is
    // idle the moment reset is asserted, even though the reset state is FETCH.
    always_comb begin
        bus.mem_address = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = '0;
        bus.block_fetch = 1'b1;
        bus.pc_advance  = 1'b0;
        bus.data_ack    = 1'b0;
        if (reset) begin
            case (state)
                ST_FETCH: begin
                    bus.mem_address = ADDR_WIDTH'(bus.fetch_address);
                    bus.mem_read    = 1'b1;
                    // A redirect in the completing cycle discards the word.
                    if (last_cycle && !bus.fetch_restart) begin
                        bus.block_fetch = 1'b0;
                        bus.pc_advance  = 1'b1;
                    end
                end
                ST_DATA: begin
                    bus.mem_address = ADDR_WIDTH'(bus.data_address);
                    bus.mem_read    = ~bus.data_write;
                    bus.mem_write   = bus.data_write;
                    bus.mem_wdata   = bus.data_wdata;
                    bus.data_ack    = last_cycle;
                end
                default: begin
                    // HALTED: bus idle, stage 0 sees NOPs.
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_FETCH;
            wait_count <= WAIT_RELOAD;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bus.fetch_restart) begin
                        wait_count <= WAIT_RELOAD;
                    end else if (!last_cycle) begin
                        wait_count <= wait_count - 4'd1;
                    end else begin
                        // Fetch completes now; data traffic beats halting so
                        // stores issued before the halt still drain.
                        wait_count <= WAIT_RELOAD;
                        if (bus.data_req) begin
                            state <= ST_DATA;
                        end else if (bus.halting) begin
                            state <= ST_HALTED;
                        end
                    end
                end
                ST_DATA: begin
                    if (!last_cycle) begin
                        wait_count <= wait_count - 4'd1;
                    end else begin
                        wait_count <= WAIT_RELOAD;
                        state      <= bus.halting ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    // Only memory-stage traffic can wake the bus; fetching
                    // never resumes without a reset.
                    if (bus.data_req) begin
                        state      <= ST_DATA;
                        wait_count <= WAIT_RELOAD;
                    end
                end
                default: begin
                    state      <= ST_FETCH;
                    wait_count <= WAIT_RELOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Testbench for memory_sequencer: three instances (WAIT_STATES 0, 1, 2) share
// one stimulus stream; each table row selects which instance is checked.
// Memory model: mem_rdata = mem_address + 0x100.
module tb_memory_sequencer;

    logic clock;
    logic reset;
    logic [29:0] fetch_address;
    logic        fetch_restart;
    logic        halting;
    logic        data_req;
    logic        data_write;
    logic [29:0] data_address;
    logic [31:0] data_wdata;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    memory_sequencer_if #(.ADDR_WIDTH(30)) if0 ();
    memory_sequencer_if #(.ADDR_WIDTH(30)) if1 ();
    memory_sequencer_if #(.ADDR_WIDTH(30)) if2 ();

    memory_sequencer #(.ADDR_WIDTH(30), .WAIT_STATES(0)) dut0 (.clock(clock), .reset(reset), .bus(if0.master));
    memory_sequencer #(.ADDR_WIDTH(30), .WAIT_STATES(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.master));
    memory_sequencer #(.ADDR_WIDTH(30), .WAIT_STATES(2)) dut2 (.clock(clock), .reset(reset), .bus(if2.master));

    assign if0.fetch_address = fetch_address; assign if1.fetch_address = fetch_address; assign if2.fetch_address = fetch_address;
    assign if0.fetch_restart = fetch_restart; assign if1.fetch_restart = fetch_restart; assign if2.fetch_restart = fetch_restart;
    assign if0.halting       = halting;       assign if1.halting       = halting;       assign if2.halting       = halting;
    assign if0.data_req      = data_req;      assign if1.data_req      = data_req;      assign if2.data_req      = data_req;
    assign if0.data_write    = data_write;    assign if1.data_write    = data_write;    assign if2.data_write    = data_write;
    assign if0.data_address  = data_address;  assign if1.data_address  = data_address;  assign if2.data_address  = data_address;
    assign if0.data_wdata    = data_wdata;    assign if1.data_wdata    = data_wdata;    assign if2.data_wdata    = data_wdata;
    assign if0.mem_rdata = {2'b00, if0.mem_address} + 32'h100;
    assign if1.mem_rdata = {2'b00, if1.mem_address} + 32'h100;
    assign if2.mem_rdata = {2'b00, if2.mem_address} + 32'h100;

    logic        bf  [3];
    logic        pa  [3];
    logic        ack [3];
    logic        mr  [3];
    logic        mw  [3];
    logic [29:0] ma  [3];
    logic [31:0] mwd [3];
    logic [31:0] idat[3];
    logic [31:0] drd [3];

    assign bf[0] = if0.block_fetch; assign bf[1] = if1.block_fetch; assign bf[2] = if2.block_fetch;
    assign pa[0] = if0.pc_advance;  assign pa[1] = if1.pc_advance;  assign pa[2] = if2.pc_advance;
    assign ack[0] = if0.data_ack;   assign ack[1] = if1.data_ack;   assign ack[2] = if2.data_ack;
    assign mr[0] = if0.mem_read;    assign mr[1] = if1.mem_read;    assign mr[2] = if2.mem_read;
    assign mw[0] = if0.mem_write;   assign mw[1] = if1.mem_write;   assign mw[2] = if2.mem_write;
    assign ma[0] = if0.mem_address; assign ma[1] = if1.mem_address; assign ma[2] = if2.mem_address;
    assign mwd[0] = if0.mem_wdata;  assign mwd[1] = if1.mem_wdata;  assign mwd[2] = if2.mem_wdata;
    assign idat[0] = if0.instr_data; assign idat[1] = if1.instr_data; assign idat[2] = if2.instr_data;
    assign drd[0] = if0.data_rdata; assign drd[1] = if1.data_rdata; assign drd[2] = if2.data_rdata;

    typedef struct {
        logic        rst;
        int          sel;
        logic [29:0] fa;
        logic        fr, hl, dr, dw;
        logic [29:0] da;
        logic [31:0] wd;
        logic        bf, pa, ack, mr, mw, chk_ma;
        logic [29:0] ma;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic vec_t v(int rst, int sel, int fa, int fr, int hl, int dr, int dw,
                               int da, logic [31:0] wd, int ebf, int epa, int eack,
                               int emr, int emw, int cma, int ema);
        vec_t r;
        r.rst = 1'(rst); r.sel = sel; r.fa = 30'(fa);
        r.fr = 1'(fr); r.hl = 1'(hl); r.dr = 1'(dr); r.dw = 1'(dw);
        r.da = 30'(da); r.wd = wd;
        r.bf = 1'(ebf); r.pa = 1'(epa); r.ack = 1'(eack);
        r.mr = 1'(emr); r.mw = 1'(emw); r.chk_ma = 1'(cma); r.ma = 30'(ema);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(vec_t r);
        reset         = r.rst;
        fetch_address = r.fa;
        fetch_restart = r.fr;
        halting       = r.hl;
        data_req      = r.dr;
        data_write    = r.dw;
        data_address  = r.da;
        data_wdata    = r.wd;
    endtask

    initial begin
        int s;
        int cyc;
        bit got;
        vec_t idle;

        idle = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0);
        drive(idle);

        // Test 1: WAIT_STATES=0 back-to-back fetches
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        for (int a = 0; a < 4; a++)
            vt.push_back(v(1, 0, a, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, a));
        // Test 2: WAIT_STATES=2 single fetch
        vt.push_back(v(0, 2, 'h10, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 2, 'h10, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h10));
        vt.push_back(v(1, 2, 'h10, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h10));
        vt.push_back(v(1, 2, 'h10, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 'h10));
        // Test 3: WAIT_STATES=1, load raised mid-fetch waits for the fetch
        vt.push_back(v(0, 1, 8, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 1, 8, 0, 0, 1, 0, 'h40, 32'h0, 1, 0, 0, 1, 0, 1, 8));
        vt.push_back(v(1, 1, 8, 0, 0, 1, 0, 'h40, 32'h0, 0, 1, 0, 1, 0, 1, 8));
        vt.push_back(v(1, 1, 9, 0, 0, 1, 0, 'h40, 32'h0, 1, 0, 0, 1, 0, 1, 'h40));
        vt.push_back(v(1, 1, 9, 0, 0, 1, 0, 'h40, 32'h0, 1, 0, 1, 1, 0, 1, 'h40));
        vt.push_back(v(1, 1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 9));
        vt.push_back(v(1, 1, 9, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 9));
        // Test 4: WAIT_STATES=0 store, one fetch bubble
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 0, 0, 0, 0, 1, 1, 'h20, 32'hDEADBEEF, 0, 1, 0, 1, 0, 1, 0));
        vt.push_back(v(1, 0, 1, 0, 0, 1, 1, 'h20, 32'hDEADBEEF, 1, 0, 1, 0, 1, 1, 'h20));
        vt.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 1));
        vt.push_back(v(1, 0, 2, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 2));
        // Test 5: WAIT_STATES=2 restart, halt, store drains while halted
        vt.push_back(v(0, 2, 'h30, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 2, 'h30, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h30));
        vt.push_back(v(1, 2, 'h30, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h30));
        vt.push_back(v(1, 2, 'h30, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h30));
        vt.push_back(v(1, 2, 'h30, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h30));
        vt.push_back(v(1, 2, 'h30, 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 'h30));
        vt.push_back(v(1, 2, 'h30, 1, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 2, 'h30, 0, 1, 1, 1, 'h24, 32'h12345678, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 2, 'h30, 0, 1, 1, 1, 'h24, 32'h12345678, 1, 0, 0, 0, 1, 1, 'h24));
        vt.push_back(v(1, 2, 'h30, 0, 1, 1, 1, 'h24, 32'h12345678, 1, 0, 0, 0, 1, 1, 'h24));
        vt.push_back(v(1, 2, 'h30, 0, 1, 1, 1, 'h24, 32'h12345678, 1, 0, 1, 0, 1, 1, 'h24));
        vt.push_back(v(1, 2, 'h30, 0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
        // Test 6: WAIT_STATES=1 reset in the final DATA cycle, then resume
        vt.push_back(v(0, 1, 'h50, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 1, 'h50, 0, 0, 1, 0, 'h44, 32'h0, 1, 0, 0, 1, 0, 1, 'h50));
        vt.push_back(v(1, 1, 'h50, 0, 0, 1, 0, 'h44, 32'h0, 0, 1, 0, 1, 0, 1, 'h50));
        vt.push_back(v(1, 1, 'h50, 0, 0, 1, 0, 'h44, 32'h0, 1, 0, 0, 1, 0, 1, 'h44));
        vt.push_back(v(0, 1, 'h50, 0, 0, 1, 0, 'h44, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 1, 'h50, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 1, 'h50));
        vt.push_back(v(1, 1, 'h50, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 1, 'h50));
        // Test 7: WAIT_STATES=0, data_req wins over halting, then halt after load
        vt.push_back(v(0, 0, 'h60, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        vt.push_back(v(1, 0, 'h60, 0, 1, 1, 0, 'h61, 32'h0, 0, 1, 0, 1, 0, 1, 'h60));
        vt.push_back(v(1, 0, 'h60, 0, 1, 1, 0, 'h61, 32'h0, 1, 0, 1, 1, 0, 1, 'h61));
        vt.push_back(v(1, 0, 'h60, 0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            @(posedge clock); #1;
            drive(vt[i]);
            if (vt[i].pa) iq.push_back({2'b00, vt[i].fa} + 32'h100);
            if (vt[i].ack && !vt[i].dw) dq.push_back({2'b00, vt[i].da} + 32'h100);
            @(negedge clock);
            s = vt[i].sel;
            chk($sformatf("row%0d block_fetch", i), 32'(bf[s]), 32'(vt[i].bf));
            chk($sformatf("row%0d pc_advance", i), 32'(pa[s]), 32'(vt[i].pa));
            chk($sformatf("row%0d data_ack", i), 32'(ack[s]), 32'(vt[i].ack));
            chk($sformatf("row%0d mem_read", i), 32'(mr[s]), 32'(vt[i].mr));
            chk($sformatf("row%0d mem_write", i), 32'(mw[s]), 32'(vt[i].mw));
            if (vt[i].chk_ma) chk($sformatf("row%0d mem_address", i), 32'(ma[s]), 32'(vt[i].ma));
            if (vt[i].mw) chk($sformatf("row%0d mem_wdata", i), mwd[s], vt[i].wd);
            if (!vt[i].rst) chk($sformatf("row%0d mem_wdata_reset", i), mwd[s], 32'h0);
            if (pa[s]) begin
                if (iq.size() == 0) chk($sformatf("row%0d instr_sb_underflow", i), 32'd1, 32'd0);
                else chk($sformatf("row%0d instr_data", i), idat[s], iq.pop_front());
            end
            if (ack[s] && !vt[i].dw) begin
                if (dq.size() == 0) chk($sformatf("row%0d load_sb_underflow", i), 32'd1, 32'd0);
                else chk($sformatf("row%0d data_rdata", i), drd[s], dq.pop_front());
            end
        end
        chk("instr_sb_drained", 32'(iq.size()), 32'd0);
        chk("load_sb_drained", 32'(dq.size()), 32'd0);

        // WAIT_STATES=2: halting held from the first cycle of a fetch only
        // takes effect once that fetch completes on its third cycle.
        @(posedge clock); #1;
        drive(idle);
        @(posedge clock); #1;
        reset         = 1'b1;
        fetch_address = 30'h70;
        halting       = 1'b1;
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            cyc = k + 1;
            if (pa[2]) begin
                got = 1'b1;
                break;
            end
        end
        chk("halt_mid_fetch_completed", 32'(got), 32'd1);
        chk("halt_mid_fetch_latency", 32'(cyc), 32'd3);
        chk("halt_mid_fetch_instr", idat[2], 32'h170);
        @(negedge clock);
        chk("halted_mem_read", 32'(mr[2]), 32'd0);
        chk("halted_block_fetch", 32'(bf[2]), 32'd1);
        chk("halted_pc_advance", 32'(pa[2]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
